// File: rtl/mem_bus_ctrl.sv
// Purpose : single-outstanding load/store controller for the word-addressed
//           Memory on the shared tristate Mem_Bus.
// Latency : request accepted at edge N, rsp_valid high N+1..N+2; max one
//           access per 2 cycles.
// Backpressure: req_ready drops for the ACCESS cycle. A request presented
//           while req_ready=0 is ignored, so the CPU holds it until accepted.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   req_valid/ready  request handshake; req_we, req_addr, req_wdata payload
//   rsp_valid        one-cycle completion pulse (loads and stores)
//   rsp_rdata        last load data, held between load responses
//   rsp_err          out-of-range flag, qualified by rsp_valid
//   CS, WE, ADDR     memory control (registered)
//   Mem_Bus          shared data bus, driven here only during a store ACCESS
//
// Optional feature: define MEM_CTRL_ADDR_CHECK_EN to range-check req_addr
// against DEPTH. Out-of-range requests keep the normal 2-cycle cadence but
// never assert CS and complete with rsp_err=1.

module mem_bus_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [31:0]       Mem_Bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        we_q;
  logic        oob_q;
  logic [31:0] wdata_q;
  logic        in_range;

`ifdef MEM_CTRL_ADDR_CHECK_EN
  assign in_range = (req_addr < ADDR_W'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  // CS and WE are both high only in ACCESS of an in-range store, so the
  // controller releases the bus for the whole IDLE turnaround cycle and
  // never overlaps with the memory's read drive.
  assign Mem_Bus = (CS && WE) ? wdata_q : {32{1'bz}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      CS        <= 1'b0;
      WE        <= 1'b0;
      ADDR      <= '0;
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      // response flags are single-cycle pulses
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            oob_q     <= !in_range;
            ADDR      <= req_addr;
            CS        <= in_range;
            WE        <= req_we && in_range;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // memory put the read word on the bus at the falling edge inside
          // this cycle; capture it as we leave ACCESS
          if (!we_q && !oob_q) begin
            rsp_rdata <= Mem_Bus;
          end
          rsp_valid <= 1'b1;
          rsp_err   <= oob_q;
          CS        <= 1'b0;
          WE        <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
